// File: rtl/alu_arbiter_n2t.sv
// Round-robin arbiter sharing the Hack ALU gate bank between N requesters.
// Optional grant watchdog is compiled in when ARB_TIMEOUT_EN is defined.
module alu_arbiter_n2t #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15,
  localparam int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic          timeout
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  if (N < 2 || N > 8 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_chk
    $error("alu_arbiter_n2t: N must be 2..8 and MAX_HOLD 1..255");
  end

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;

  logic [IW-1:0] win, cand;
  logic          found;
  logic          rel;
  logic          expire;

  // Rotating search: first requester at or above ptr, wrapping modulo N.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign rel = done || !req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  assign expire = (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    hold_d    = (state_q == S_BUSY) ? hold_q + 8'd1 : 8'd0;
    // A normal release on the expiry edge wins; no timeout pulse then.
    timeout_d = (state_q == S_BUSY) && expire && !rel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_BUSY;
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          gnt_id_d    = win;
          ptr_d       = (win == IW'(N - 1)) ? '0 : win + 1'b1;
          busy_d      = 1'b1;
        end
      end
      S_BUSY: begin
        // ptr already advanced at grant time, so leaving BUSY leaves it alone.
        if (rel || expire) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_alu_arbiter_n2t.sv
// Bench for alu_arbiter_n2t: directed vector table, watchdog sequence and
// randomized traffic against a behavioural owner/pointer model.
module tb_alu_arbiter_n2t;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IW       = $clog2(N);
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  // Model state: current owner (-1 = none), next search start, last owner id.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_id    = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  alu_arbiter_n2t #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         r;
    logic [N-1:0] q;
    logic         d;
    logic [N-1:0] eg;
    int           eid;
    logic         eb;
  } vec_t;

  vec_t tbl[$];

  task automatic model_step(input logic r, input logic [N-1:0] q, input logic d);
    m_to = 1'b0;
    if (!r) begin
      m_owner = -1; m_ptr = 0; m_id = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (m_owner < 0 && q[i]) begin
          m_owner = i; m_id = i; m_ptr = (i + 1) % N; m_hold = 0;
        end
      end
    end else if (d || !q[m_owner]) begin
      m_owner = -1;
    end else if (TMO && m_hold == MAX_HOLD - 1) begin
      m_owner = -1; m_to = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic chk(input string nm, input logic [N-1:0] eg, input int eid,
                     input logic eb, input logic et);
    checks++;
    if (gnt !== eg || gnt_id !== IW'(eid) || busy !== eb || timeout !== et) begin
      errors++;
      $display("FAIL %s @%0t: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
               nm, $time, gnt, gnt_id, busy, timeout, eg, eid, eb, et);
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, check at +1.
  task automatic cyc(input logic r, input logic [N-1:0] q, input logic d);
    logic [N-1:0] eg;
    rst_n = r; req = q; done = d;
    @(posedge clk);
    model_step(r, q, d);
    #1;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("model", eg, m_id, m_owner >= 0, m_to);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; done = 1'b0;

    // reset
    tbl.push_back('{1'b0, 4'hF, 1'b0, 4'h0, 0, 1'b0});
    tbl.push_back('{1'b0, 4'hF, 1'b0, 4'h0, 0, 1'b0});
    tbl.push_back('{1'b0, 4'hF, 1'b0, 4'h0, 0, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 1'b0, 4'h1, 0, 1'b1});
    tbl.push_back('{1'b1, 4'hF, 1'b1, 4'h0, 0, 1'b0});
    // single request, release, re-grant
    tbl.push_back('{1'b1, 4'h4, 1'b0, 4'h4, 2, 1'b1});
    tbl.push_back('{1'b1, 4'h4, 1'b1, 4'h0, 2, 1'b0});
    tbl.push_back('{1'b1, 4'h4, 1'b0, 4'h4, 2, 1'b1});
    tbl.push_back('{1'b1, 4'h4, 1'b1, 4'h0, 2, 1'b0});
    // fairness from ptr=0: 0,1,2,3,0,1
    tbl.push_back('{1'b0, 4'hF, 1'b0, 4'h0, 0, 1'b0});
    for (int g = 0; g < 6; g++) begin
      logic [N-1:0] oh;
      oh = '0; oh[g % N] = 1'b1;
      tbl.push_back('{1'b1, 4'hF, 1'b0, oh, g % N, 1'b1});
      if (g < 5) tbl.push_back('{1'b1, 4'hF, 1'b0, oh, g % N, 1'b1});
      tbl.push_back('{1'b1, 4'hF, 1'b1, 4'h0, g % N, 1'b0});
    end
    // owner drop with non-owner toggling (ptr=2 here)
    tbl.push_back('{1'b1, 4'h1, 1'b0, 4'h1, 0, 1'b1});
    tbl.push_back('{1'b1, 4'h1, 1'b1, 4'h0, 0, 1'b0});
    tbl.push_back('{1'b1, 4'h3, 1'b0, 4'h2, 1, 1'b1});
    tbl.push_back('{1'b1, 4'h2, 1'b0, 4'h2, 1, 1'b1});
    tbl.push_back('{1'b1, 4'h3, 1'b0, 4'h2, 1, 1'b1});
    tbl.push_back('{1'b1, 4'h1, 1'b0, 4'h0, 1, 1'b0});
    tbl.push_back('{1'b1, 4'h3, 1'b0, 4'h1, 0, 1'b1});
    tbl.push_back('{1'b1, 4'h3, 1'b1, 4'h0, 0, 1'b0});
    // reset mid-grant, owner 3
    tbl.push_back('{1'b1, 4'h8, 1'b0, 4'h8, 3, 1'b1});
    tbl.push_back('{1'b0, 4'h9, 1'b0, 4'h0, 0, 1'b0});
    tbl.push_back('{1'b1, 4'h9, 1'b0, 4'h1, 0, 1'b1});
    tbl.push_back('{1'b1, 4'h9, 1'b1, 4'h0, 0, 1'b0});
    // reset mid-grant must clear ptr (ptr=2 before reset would pick 2)
    tbl.push_back('{1'b1, 4'h2, 1'b0, 4'h2, 1, 1'b1});
    tbl.push_back('{1'b0, 4'h6, 1'b0, 4'h0, 0, 1'b0});
    tbl.push_back('{1'b1, 4'h6, 1'b0, 4'h2, 1, 1'b1});
    tbl.push_back('{1'b1, 4'h6, 1'b1, 4'h0, 1, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].q, tbl[i].d);
      chk($sformatf("vec%0d", i), tbl[i].eg, tbl[i].eid, tbl[i].eb, 1'b0);
    end

    // watchdog: ptr=2, only requester 0 asks and never releases
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      cyc(1'b1, 4'h1, 1'b0);
      chk($sformatf("wd_hold%0d", c), 4'h1, 0, 1'b1, 1'b0);
    end
    cyc(1'b1, 4'h1, 1'b0);
    chk("wd_expire", 4'h0, 0, 1'b0, 1'b1);
    cyc(1'b1, 4'h1, 1'b0);
    chk("wd_regrant", 4'h1, 0, 1'b1, 1'b0);
`else
    for (int c = 0; c < 100; c++) begin
      cyc(1'b1, 4'h1, 1'b0);
      chk($sformatf("nowd_hold%0d", c), 4'h1, 0, 1'b1, 1'b0);
    end
`endif
    cyc(1'b1, 4'h1, 1'b1);
    chk("wd_release", 4'h0, 0, 1'b0, 1'b0);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      cyc($urandom_range(0, 49) != 0, N'($urandom), $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_n2t.md
# alu_arbiter_n2t

Round-robin arbiter that shares the single Hack ALU/logic datapath (And/Or/Xor/Not gate bank) between N requesters. Each requester raises a request, receives a registered one-hot grant, uses the datapath, and releases with `done` or by dropping its request. The block sits between the requester front-ends and the operand mux that drives the shared gate bank; `gnt_id` drives that mux select directly.

## Interface
- `N`, 4: number of requesters, 2..8.
- `MAX_HOLD`, 15: maximum grant length in cycles, 1..255. Used only when `ARB_TIMEOUT_EN` is defined.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `req` input N: level request per requester.
- `done` input 1: one-cycle release pulse from the current owner. Ignored in IDLE.
- `gnt` output N: one-hot grant. Registered. All zeros when no grant is active.
- `gnt_id` output $clog2(N): index of the owner. Registered. Holds its last value when idle.
- `busy` output 1: high while a grant is active (state BUSY).
- `timeout` output 1: one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- There are two states, IDLE and BUSY. The round-robin pointer `ptr` has width $clog2(N).
- IDLE, with any `req` bit set at an edge:
  - Search from `ptr` upward, modulo N. The first set bit i wins.
  - Set `gnt`=1<<i, `gnt_id`=i, and `ptr`=(i+1) mod N.
  - Go to BUSY.
- IDLE, with `req`=0: stay in IDLE. All outputs stay inactive.
- BUSY: `gnt` and `gnt_id` hold stable. `req` bits from non-owners have no effect.
- BUSY to IDLE, at the edge where any of these holds:
  - `done`=1, or
  - `req[gnt_id]`=0, or
  - the watchdog expires.
  - On that edge: `gnt`=0 and `busy`=0. `ptr` is unchanged because it was already advanced when the grant was issued.
- If `done`=1 and the owner drops `req` in the same cycle, this counts as a single release.
- There is always one IDLE cycle between grants. No back-to-back grants.
- `ptr` wraps from N-1 to 0.
- `gnt` is never multi-hot. `gnt` is nonzero exactly when `busy`=1.

## Timing
- Reset (`rst_n`=0 sampled at an edge): state=IDLE, `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0, `ptr`=0, hold counter=0.
  - Reset overrides everything, including during BUSY.
  - An interrupted owner must re-request.
- Grant latency is 1 cycle. If `req` is sampled high at edge k while in IDLE, `gnt` is high after edge k.
- Release latency is 1 cycle. If `done` is sampled at edge k, `gnt` is low after edge k.
- Re-grant: the earliest new grant is visible after edge k+1.
- `timeout` is high for exactly the one cycle after the revoking edge. It is low otherwise.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on grant and increments every BUSY cycle.
  - Expiry happens at the edge where the counter equals MAX_HOLD-1 and no other release applies. Result: IDLE, `gnt`=0, `timeout`=1 for one cycle.
  - `gnt` is therefore high for at most MAX_HOLD cycles.
  - If `done` arrives on the expiry edge, it is a normal release and `timeout` stays 0.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - `timeout` is tied to 0.
  - A grant is held until `done` or the owner drops its request, with no upper bound.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'b1111 for 3 cycles. Required: `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0 throughout. Release reset: first grant after the next edge is `gnt`=4'b0001.
- Single request: `req`=4'b0100. Required: `gnt`=4'b0100, `gnt_id`=2, `busy`=1 one edge later. Pulse `done` for one cycle: `gnt`=0 after that edge. Then `gnt`=4'b0100 again one edge later.
- Fairness: hold `req`=4'b1111 and pulse `done` 2 cycles after each grant. Required grant order: 0,1,2,3,0,1, with exactly one `busy`=0 cycle between grants.
- Owner drop plus non-owner activity: owner is 1 (`req`=4'b0011). Toggle `req[0]` during BUSY: `gnt` stays 4'b0010. Clear `req[1]`: `gnt`=0 after that edge. Next grant goes to 0.
- Watchdog, with `ARB_TIMEOUT_EN` and MAX_HOLD=4: `req`=4'b0001, `done`=0. Required: `gnt`=4'b0001 for exactly 4 cycles, then `timeout`=1 for one cycle with `gnt`=0, then a re-grant to 0.
  - With the macro undefined: `gnt` stays 4'b0001 for 100 cycles and `timeout` is always 0.
- Reset mid-grant: during BUSY with owner 3, assert `rst_n`=0 for one edge. Required: `gnt`=0 and `ptr`=0 after that edge. With `req`=4'b1001, the next grant goes to 0.
